// File: rtl/fitbit_tick_scheduler_pkg.sv
// Shared types and width helpers for the tick scheduler and its channels.
package fitbit_tick_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int N_CH_DEF = 4;
   localparam int CH_W     = ch_width(N_CH_DEF);

endpackage

// File: rtl/fitbit_tick_chan.sv
// One tick channel: divisor register, base-tick counter and one-cycle tick pulse.
module fitbit_tick_chan #(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 32
) (
   input  logic             clk100Mhz,
   input  logic             reset,
   input  logic             i_wrap,
   input  logic             i_clr,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_wr_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_tick;
   logic             w_last;

   assign w_last = (r_cnt == (r_div - 1'b1));
   assign o_tick = r_tick;

   // A write takes the wrap it lands on, so the reconfigured channel stays quiet there.
   always_ff @(posedge clk100Mhz or posedge reset) begin
      if (reset) begin
         r_div  <= DIV_W'(DEF_DIV);
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (i_wr) begin
            r_div <= i_wr_div;
            r_cnt <= '0;
         end else if (i_clr || (r_div == '0)) begin
            r_cnt <= '0;
         end else if (i_wrap) begin
            if (w_last) begin
               r_cnt  <= '0;
               r_tick <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fitbit_tick_scheduler.sv
// Shared prescaler, run/stop FSM and configuration latch feeding N_CH tick channels.
//   state   | meaning
//   IDLE    | stopped, prescaler held at 0, config written directly
//   RUN     | prescaler counting, ticks issued
//   PEND    | running with one config latched, applied at next wrap
module fitbit_tick_scheduler
   import fitbit_tick_scheduler_pkg::*;
#(
   parameter  int BASE_DIV = 3125000,
   parameter  int N_CH     = 4,
   parameter  int DIV_W    = 8,
   parameter  int DEF_DIV  = 32,
   localparam int CW       = ch_width(N_CH)
) (
   input  logic             clk100Mhz,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   output logic             running,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CW-1:0]    cfg_chan,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             base_tick,
   output logic [N_CH-1:0]  tick
);

   localparam int            PW       = $clog2(BASE_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(BASE_DIV - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PW-1:0]    r_pre;
   logic             r_running;
   logic             r_base_tick;
   logic [CW-1:0]    r_pend_chan;
   logic [DIV_W-1:0] r_pend_div;

   logic             w_active;
   logic             w_wrap;
   logic             w_latch;
   logic             w_wr;
   logic [CW-1:0]    w_wr_chan;
   logic [DIV_W-1:0] w_wr_div;

   assign w_active  = (r_state != ST_IDLE);
   assign w_wrap    = w_active && !stop && (r_pre == PRE_LAST);
   assign cfg_ready = (r_state != ST_PEND);
   assign running   = r_running;
   assign base_tick = r_base_tick;

   always_ff @(posedge clk100Mhz or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A stop never drops a config: whatever is pending or offered is written on the way out.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_wr        = 1'b0;
      w_wr_chan   = cfg_chan;
      w_wr_div    = cfg_div;
      unique case (r_state)
         ST_IDLE: begin
            w_wr = cfg_valid;
            if (start && !stop) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_wr        = cfg_valid;
            end else if (cfg_valid) begin
               w_state_nxt = ST_PEND;
               w_latch     = 1'b1;
            end
         end
         ST_PEND: begin
            w_wr_chan = r_pend_chan;
            w_wr_div  = r_pend_div;
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_wr        = 1'b1;
            end else if (w_wrap) begin
               w_state_nxt = ST_RUN;
               w_wr        = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk100Mhz or posedge reset) begin
      if (reset) begin
         r_pre       <= '0;
         r_running   <= 1'b0;
         r_base_tick <= 1'b0;
         r_pend_chan <= '0;
         r_pend_div  <= '0;
      end else begin
         r_running   <= (w_state_nxt != ST_IDLE);
         r_base_tick <= w_wrap;
         if (!w_active || stop || w_wrap) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
         if (w_latch) begin
            r_pend_chan <= cfg_chan;
            r_pend_div  <= cfg_div;
         end
      end
   end

   // Channel numbers at or above N_CH match no instance and are silently dropped.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      fitbit_tick_chan #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk100Mhz (clk100Mhz),
         .reset     (reset),
         .i_wrap    (w_wrap),
         .i_clr     (stop),
         .i_wr      (w_wr && (w_wr_chan == CW'(gi))),
         .i_wr_div  (w_wr_div),
         .o_tick    (tick[gi])
      );
   end

endmodule

// File: tb/tb_fitbit_tick_scheduler.sv
// Directed bench for fitbit_tick_scheduler with BASE_DIV=4, DEF_DIV=2 (plus an N_CH=3 instance).
module tb_fitbit_tick_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, stop, cfg_valid;
   logic [1:0] cfg_chan;
   logic [7:0] cfg_div;
   logic       running, cfg_ready, base_tick;
   logic [3:0] tick;

   logic       s3_start, s3_stop, s3_cfg_valid;
   logic [1:0] s3_cfg_chan;
   logic [7:0] s3_cfg_div;
   logic       s3_running, s3_cfg_ready, s3_base_tick;
   logic [2:0] s3_tick;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fitbit_tick_scheduler #(.BASE_DIV(4), .N_CH(4), .DIV_W(8), .DEF_DIV(2)) u_dut (
      .clk100Mhz (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .running   (running),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .base_tick (base_tick),
      .tick      (tick)
   );

   fitbit_tick_scheduler #(.BASE_DIV(4), .N_CH(3), .DIV_W(8), .DEF_DIV(2)) u_dut3 (
      .clk100Mhz (clk),
      .reset     (reset),
      .start     (s3_start),
      .stop      (s3_stop),
      .running   (s3_running),
      .cfg_valid (s3_cfg_valid),
      .cfg_ready (s3_cfg_ready),
      .cfg_chan  (s3_cfg_chan),
      .cfg_div   (s3_cfg_div),
      .base_tick (s3_base_tick),
      .tick      (s3_tick)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic r, input logic rdy,
                           input logic b, input logic [3:0] t);
      chk(tag, {25'd0, running, cfg_ready, base_tick, tick}, {25'd0, r, rdy, b, t});
   endtask

   function automatic logic exp_t(input logic b, input int k, input int d, input int k0);
      if (d == 0) return 1'b0;
      return b && (k > k0) && (((k - k0) % d) == 0);
   endfunction

   // Cycle c counts edges since the start edge (c=1 right after it). Base ticks land at
   // c = 5, 9, 13, ...; k is the number of base ticks seen so far.
   task automatic window(input string tag, input int lo, input int hi, input logic rdy,
                         input int d0, input int d1, input int d2, input int d3, input int k3);
      logic       b;
      int         k;
      logic [3:0] t;
      for (int c = lo; c <= hi; c++) begin
         step();
         start     = 1'b0;
         stop      = 1'b0;
         cfg_valid = 1'b0;
         b    = (c >= 5) && (((c - 1) % 4) == 0);
         k    = (c - 1) / 4;
         t[0] = exp_t(b, k, d0, 0);
         t[1] = exp_t(b, k, d1, 0);
         t[2] = exp_t(b, k, d2, 0);
         t[3] = exp_t(b, k, d3, k3);
         chk_outs($sformatf("%s_c%0d", tag, c), 1'b1, rdy, b, t);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic b;
      int   k;
      reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_div = 8'd0;
      s3_start = 1'b0; s3_stop = 1'b0; s3_cfg_valid = 1'b0; s3_cfg_chan = 2'd0; s3_cfg_div = 8'd0;
      #12;
      chk_outs("reset", 1'b0, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // 1: default cadence
      start = 1'b1;
      window("t1", 1, 20, 1'b1, 2, 2, 2, 2, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_outs("t1_stop", 1'b0, 1'b1, 1'b0, 4'h0);
      chk("t1_pre", 32'(u_dut.r_pre), 32'd0);

      // 2: IDLE config, ch1 div 1 and ch2 div 0
      cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd1;
      step();
      cfg_chan = 2'd2; cfg_div = 8'd0;
      step();
      cfg_valid = 1'b0;
      chk_outs("t2_idle", 1'b0, 1'b1, 1'b0, 4'h0);
      start = 1'b1;
      window("t2", 1, 26, 1'b1, 2, 1, 0, 2, 0);

      // 3: RUN config mid-period, ch3 div 3, applied at the wrap of base tick 7
      cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd3;
      window("t3p", 27, 28, 1'b0, 2, 1, 0, 3, 7);
      window("t3", 29, 60, 1'b1, 2, 1, 0, 3, 7);

      // 4: start and stop together on a would-be wrap edge
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk_outs("t4_stop", 1'b0, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_outs($sformatf("t4_idle%0d", i), 1'b0, 1'b1, 1'b0, 4'h0);
         chk($sformatf("t4_pre%0d", i), 32'(u_dut.r_pre), 32'd0);
      end

      // 6: stop while PEND still writes the latched ch0 div 1
      start = 1'b1;
      window("t6a", 1, 6, 1'b1, 2, 1, 0, 3, 0);
      cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd1;
      window("t6p", 7, 7, 1'b0, 2, 1, 0, 3, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_outs("t6_stop", 1'b0, 1'b1, 1'b0, 4'h0);
      start = 1'b1;
      window("t6", 1, 20, 1'b1, 1, 1, 0, 3, 0);

      // 5: async reset during a base tick with ch2 config pending
      cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd5;
      step();
      cfg_valid = 1'b0;
      chk_outs("t5_pend", 1'b1, 1'b0, 1'b1, 4'b0011);
      #2;
      reset = 1'b1;
      #1;
      chk_outs("t5_async", 1'b0, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk_outs("t5_idle", 1'b0, 1'b1, 1'b0, 4'h0);
      start = 1'b1;
      window("t5", 1, 20, 1'b1, 2, 2, 2, 2, 0);

      // out-of-range channel on the 3-channel instance
      s3_cfg_valid = 1'b1; s3_cfg_chan = 2'd3; s3_cfg_div = 8'd1;
      step();
      s3_cfg_valid = 1'b0;
      chk("oor_ready", 32'(s3_cfg_ready), 32'd1);
      s3_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         s3_start = 1'b0;
         b = (c >= 5) && (((c - 1) % 4) == 0);
         k = (c - 1) / 4;
         chk($sformatf("oor_c%0d", c), {27'd0, s3_running, s3_base_tick, s3_tick},
             {27'd0, 1'b1, b, ((b && (k % 2 == 0)) ? 3'b111 : 3'b000)});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
